sym_err_meas_ctrl: RTL



---
 rtl/sym_err_meas_ctrl_pkg.sv | 15 +
 rtl/sym_err_meas_ctrl_sat_counter.sv | 24 ++
 rtl/sym_err_meas_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sym_err_meas_ctrl_pkg.sv
// Shared types and constants for the symbol-error measurement controller.
// The LFSR period constant is also used by the lfsr_gen_max benches.
package sym_err_meas_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam int DEF_CNT_W   = 22;
  localparam int LFSR_PERIOD = (1 << 22) - 1;

endpackage

// File: rtl/sym_err_meas_ctrl_sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter
  import sym_err_meas_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sym_err_meas_ctrl.sv
// Sequences one symbol-error measurement over an LFSR period and latches the totals.
// Optional macro SYM_ERR_MEAS_SPLIT_EN adds separate in-phase/quadrature error counts.
module sym_err_meas_ctrl
  import sym_err_meas_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MAX_SYMS    = LFSR_PERIOD,
  parameter int ARM_TIMEOUT = 4194304
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sym_clk_ena,
  input  logic             lfsr_period,
  input  logic             start,
  input  logic             abort,
  input  logic             err_i,
  input  logic             err_q,
  output logic             busy,
  output logic             acc_en,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] sym_count,
  output logic [CNT_W:0]   err_count,
  output logic [1:0]       state
`ifdef SYM_ERR_MEAS_SPLIT_EN
  ,output logic [CNT_W-1:0] err_i_count
  ,output logic [CNT_W-1:0] err_q_count
`endif
);

  localparam int TO_W = $clog2(ARM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(MAX_SYMS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ARM_TIMEOUT - 1);

  state_t             r_state;
  logic               r_start_d;
  logic               r_busy;
  logic               r_done;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_sym_count;
  logic [CNT_W:0]     r_err_count;

  logic               w_start_edge;
  logic               w_arm;
  logic               w_count;
  logic               w_cap_hit;
  logic               w_to_en;
  logic               w_to_hit;
  logic [CNT_W-1:0]   w_sym_cnt;
  logic [CNT_W:0]     w_err_cnt;
  logic [TO_W-1:0]    w_to_cnt;

  assign w_start_edge = start & ~r_start_d;
  assign w_arm        = (r_state == ST_IDLE) & w_start_edge & ~abort;

  // The aligning marker in ARM is the first counted symbol; the closing marker in RUN is not.
  assign w_count   = sym_clk_ena & ~abort &
                     (((r_state == ST_ARM) & lfsr_period) | ((r_state == ST_RUN) & ~lfsr_period));
  assign w_cap_hit = (w_sym_cnt == SYM_LAST);
  assign w_to_en   = sym_clk_ena & ~abort & (r_state == ST_ARM) & ~lfsr_period;
  assign w_to_hit  = (w_to_cnt == TO_LAST);

  sat_counter #(.W(CNT_W)) u_sym_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_arm),
    .en      (w_count),
    .count   (w_sym_cnt)
  );

  sat_counter #(.W(CNT_W + 1)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_arm),
    .en      (w_count & (err_i | err_q)),
    .count   (w_err_cnt)
  );

  sat_counter #(.W(TO_W)) u_to_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_arm),
    .en      (w_to_en),
    .count   (w_to_cnt)
  );

`ifdef SYM_ERR_MEAS_SPLIT_EN
  logic [CNT_W-1:0] w_err_i_cnt;
  logic [CNT_W-1:0] w_err_q_cnt;
  logic [CNT_W-1:0] r_err_i_count;
  logic [CNT_W-1:0] r_err_q_count;

  sat_counter #(.W(CNT_W)) u_err_i_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_arm),
    .en      (w_count & err_i),
    .count   (w_err_i_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_q_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_arm),
    .en      (w_count & err_q),
    .count   (w_err_q_cnt)
  );

  assign err_i_count = r_err_i_count;
  assign err_q_count = r_err_q_count;
`endif

  // Abort overrides everything; results and the sticky timeout survive it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_start_d   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_sym_count <= '0;
      r_err_count <= '0;
`ifdef SYM_ERR_MEAS_SPLIT_EN
      r_err_i_count <= '0;
      r_err_q_count <= '0;
`endif
    end else begin
      r_start_d <= start;
      r_done    <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start_edge) begin
              r_state   <= ST_ARM;
              r_busy    <= 1'b1;
              r_timeout <= 1'b0;
            end
          end
          ST_ARM: begin
            if (sym_clk_ena && lfsr_period) begin
              r_state <= w_cap_hit ? ST_LATCH : ST_RUN;
              r_busy  <= ~w_cap_hit;
            end else if (w_to_en && w_to_hit) begin
              r_state   <= ST_IDLE;
              r_busy    <= 1'b0;
              r_timeout <= 1'b1;
            end
          end
          ST_RUN: begin
            if (sym_clk_ena && (lfsr_period || w_cap_hit)) begin
              r_state <= ST_LATCH;
              r_busy  <= 1'b0;
            end
          end
          ST_LATCH: begin
            r_sym_count <= w_sym_cnt;
            r_err_count <= w_err_cnt;
`ifdef SYM_ERR_MEAS_SPLIT_EN
            r_err_i_count <= w_err_i_cnt;
            r_err_q_count <= w_err_q_cnt;
`endif
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy      = r_busy;
  assign acc_en    = w_count;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign sym_count = r_sym_count;
  assign err_count = r_err_count;
  assign state     = r_state;

endmodule
